// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the legal range of the operand width parameter.
package serial_sub_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fs_nor.sv
// 1-bit full subtractor (a - b - bin) built only from 2-input NOR gates:
// two NOR half subtractors in series, then a NOR-composed OR that merges
// their borrows. Purely combinational.
module fs_nor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // First half subtractor: a - b
    logic h1_n1, h1_bo, h1_t, h1_xn, h1_d;
    // Second half subtractor: (a ^ b) - bin
    logic h2_n1, h2_bo, h2_t, h2_xn;
    // Borrow merge
    logic bo_n;

    // Within each half subtractor the gate nor(x, nor(x, y)) reduces to ~x & y,
    // which is exactly the half-subtractor borrow, so it is reused for the XOR.
    assign h1_n1 = ~(a | b);
    assign h1_bo = ~(a | h1_n1);
    assign h1_t  = ~(b | h1_n1);
    assign h1_xn = ~(h1_bo | h1_t);
    assign h1_d  = ~(h1_xn | h1_xn);

    assign h2_n1 = ~(h1_d | bin);
    assign h2_bo = ~(h1_d | h2_n1);
    assign h2_t  = ~(bin | h2_n1);
    assign h2_xn = ~(h2_bo | h2_t);
    assign d     = ~(h2_xn | h2_xn);

    assign bo_n  = ~(h1_bo | h2_bo);
    assign bout  = ~(bo_n | bo_n);

endmodule

// File: rtl/serial_sub_nor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a
// single NOR-only full-subtractor cell with a registered borrow.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output `ovf` and the two flops that hold the captured operand MSBs.
module serial_sub_nor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_sub_nor: WIDTH out of legal range");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bq_q, bq_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             am_q, am_d;
    logic             bm_q, bm_d;
    logic             ovf_q, ovf_d;
`endif

    logic             cell_d, cell_bo;
    logic             last_bit;
    logic [WIDTH-1:0] shift_w;

    fs_nor u_cell (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .bin  (bq_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // The partial result keeps only WIDTH-1 bits; the final bit comes straight
    // from the cell on the last shift cycle and completes the word.
    assign shift_w  = {cell_d, res_q};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath update: load on accepted start, shift while busy.
    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bq_d     = bq_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        am_d     = am_q;
        bm_d     = bm_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_SHIFT;
                    ra_d    = a;
                    rb_d    = b;
                    res_d   = '0;
                    bq_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
`endif
                end
            end
            S_SHIFT: begin
                ra_d  = {1'b0, ra_q[WIDTH-1:1]};
                rb_d  = {1'b0, rb_q[WIDTH-1:1]};
                res_d = shift_w[WIDTH-1:1];
                bq_d  = cell_bo;
                if (last_bit) begin
                    state_d  = S_DONE;
                    diff_d   = shift_w;
                    borrow_d = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (am_q ^ bm_q) & (am_q ^ cell_d);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bq_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            am_q     <= 1'b0;
            bm_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bq_q     <= bq_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            am_q     <= am_d;
            bm_q     <= bm_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_nor.sv
// Self-checking bench for serial_sub_nor: an arithmetic reference model
// checked every cycle on the WIDTH=8 instance, directed literal vectors,
// back-to-back, reset abort, and a randomized WIDTH=13 instance.
module tb_serial_sub_nor;

    localparam int W   = 8;
    localparam int W13 = 13;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy, done, borrow;
    logic [W-1:0]  diff;

    logic           start13 = 1'b0;
    logic [W13-1:0] a13     = '0;
    logic [W13-1:0] b13     = '0;
    logic           busy13, done13, borrow13;
    logic [W13-1:0] diff13;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf, ovf13;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_sub_nor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    serial_sub_nor #(.WIDTH(W13)) dut13 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start13),
        .a      (a13),
        .b      (b13),
        .busy   (busy13),
        .done   (done13),
        .diff   (diff13),
        .borrow (borrow13)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf13)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation takes W busy cycles, then the
    // arithmetic result appears with a one-cycle done; results hold afterwards.
    int           m_rem    = 0;
    logic         m_done   = 1'b0;
    logic [W-1:0] m_a      = '0;
    logic [W-1:0] m_b      = '0;
    logic [W-1:0] m_diff   = '0;
    logic         m_borrow = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    logic         m_ovf    = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem    = 0;
            m_done   = 1'b0;
            m_diff   = '0;
            m_borrow = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            m_ovf    = 1'b0;
`endif
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = 1'b0;
            if (m_rem == 0) begin
                m_done   = 1'b1;
                m_diff   = m_a - m_b;
                m_borrow = (m_a < m_b);
`ifdef SERIAL_SUB_OVF_EN
                m_ovf    = (m_a[W-1] != m_b[W-1]) && (m_diff[W-1] != m_a[W-1]);
`endif
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_a   = a;
                m_b   = b;
                m_rem = W;
            end
        end
    end

    // Per-cycle comparison of the WIDTH=8 instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("busy",   32'(busy),   32'(m_rem > 0));
            checkOutput("done",   32'(done),   32'(m_done));
            checkOutput("diff",   32'(diff),   32'(m_diff));
            checkOutput("borrow", 32'(borrow), 32'(m_borrow));
`ifdef SERIAL_SUB_OVF_EN
            checkOutput("ovf",    32'(ovf),    32'(m_ovf));
`endif
        end
    end

    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb);
        @(posedge clk);
        #1;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge to the edge that samples done high.
    task automatic waitDone(output int lat);
        lat = 1;
        while (lat <= 40) begin
            @(negedge clk);
            if (done === 1'b1) return;
            lat++;
        end
    endtask

    task automatic run13(input logic [W13-1:0] va, input logic [W13-1:0] vb);
        logic [W13-1:0] exp_d;
        int lat;
        exp_d = va - vb;
        @(posedge clk);
        #1;
        a13     = va;
        b13     = vb;
        start13 = 1'b1;
        @(posedge clk);
        #1;
        start13 = 1'b0;
        a13     = 13'($urandom);
        b13     = 13'($urandom);
        lat = 1;
        while (lat <= 40) begin
            @(negedge clk);
            if (done13 === 1'b1) break;
            lat++;
        end
        checkOutput("lat13",    32'(lat),      32'(W13 + 1));
        checkOutput("busy13",   32'(busy13),   32'(0));
        checkOutput("diff13",   32'(diff13),   32'(exp_d));
        checkOutput("borrow13", 32'(borrow13), 32'(va < vb));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("ovf13",    32'(ovf13),
                    32'((va[W13-1] ^ vb[W13-1]) & (va[W13-1] ^ exp_d[W13-1])));
`endif
        @(negedge clk);
        checkOutput("done13_width", 32'(done13), 32'(0));
    endtask

    logic [W-1:0] d_a   [7] = '{8'h5A, 8'h3C, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h10};
    logic [W-1:0] d_b   [7] = '{8'h3C, 8'h5A, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h05};
    logic [W-1:0] d_diff[7] = '{8'h1E, 8'hE2, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h0B};
    logic         d_brw [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SERIAL_SUB_OVF_EN
    logic         d_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif

    logic [W-1:0] bb_a   [3] = '{8'h12, 8'hA0, 8'h01};
    logic [W-1:0] bb_b   [3] = '{8'h34, 8'h0A, 8'h02};
    logic [W-1:0] bb_diff[3] = '{8'hDE, 8'h96, 8'hFF};
    logic         bb_brw [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        int lat;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy",   32'(busy),   32'(0));
        checkOutput("rst_done",   32'(done),   32'(0));
        checkOutput("rst_diff",   32'(diff),   32'(0));
        checkOutput("rst_borrow", 32'(borrow), 32'(0));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(d_a[i], d_b[i]);
            waitDone(lat);
            checkOutput("latency",    32'(lat),    32'(9));
            checkOutput("dir_diff",   32'(diff),   32'(d_diff[i]));
            checkOutput("dir_borrow", 32'(borrow), 32'(d_brw[i]));
`ifdef SERIAL_SUB_OVF_EN
            checkOutput("dir_ovf",    32'(ovf),    32'(d_ovf[i]));
`endif
        end

        $display("[TB] back-to-back with start held high");
        @(posedge clk);
        #1;
        a     = bb_a[0];
        b     = bb_b[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            waitDone(lat);
            checkOutput("bb_latency", 32'(lat),    32'(9));
            checkOutput("bb_diff",    32'(diff),   32'(bb_diff[i]));
            checkOutput("bb_borrow",  32'(borrow), 32'(bb_brw[i]));
            if (i < 2) begin
                a = bb_a[i + 1];
                b = bb_b[i + 1];
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] reset abort during shift");
        applyStimulus(8'h5A, 8'h3C);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy",   32'(busy),   32'(0));
        checkOutput("abort_done",   32'(done),   32'(0));
        checkOutput("abort_diff",   32'(diff),   32'(0));
        checkOutput("abort_borrow", 32'(borrow), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'(done), 32'(0));
        end
        applyStimulus(8'h3C, 8'h5A);
        waitDone(lat);
        checkOutput("post_latency", 32'(lat),    32'(9));
        checkOutput("post_diff",    32'(diff),   32'(8'hE2));
        checkOutput("post_borrow",  32'(borrow), 32'(1));

        $display("[TB] random operands, WIDTH=8");
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            applyStimulus(8'($urandom), 8'($urandom));
            waitDone(lat);
            checkOutput("rnd_latency", 32'(lat), 32'(9));
        end

        $display("[TB] random operands, WIDTH=13");
        run13(13'h1FFF, 13'h0001);
        run13(13'h0000, 13'h1FFF);
        for (int i = 0; i < 1000; i++) begin
            run13(13'($urandom), 13'($urandom));
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
